// File: rtl/pin_ctrl_pkg.sv
// pin_ctrl_pkg
// Shared definitions for the PIN attempt controller: FSM state encoding,
// single-byte response codes sent back over the UART, received-character
// constants and small character-classification helpers.
package pin_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CHECK   = 3'd2,
        ST_RESPOND = 3'd3,
        ST_LOCKOUT = 3'd4
    } pin_state_t;

    // Response bytes
    localparam logic [7:0] RESP_OK   = 8'h4F;  // 'O'
    localparam logic [7:0] RESP_FAIL = 8'h46;  // 'F'
    localparam logic [7:0] RESP_ERR  = 8'h45;  // 'E'
    localparam logic [7:0] RESP_LOCK = 8'h4C;  // 'L'

    // Received characters
    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_ZERO = 8'h30;
    localparam logic [7:0] CHAR_NINE = 8'h39;

    // True for ASCII '0'..'9'.
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CHAR_ZERO) && (b <= CHAR_NINE);
    endfunction

    // ASCII digit to BCD: the low nibble of '0'..'9' is the digit value.
    function automatic logic [3:0] ascii_to_bcd(input logic [7:0] b);
        return b[3:0];
    endfunction

endpackage

// File: rtl/pin_compare.sv
// pin_compare
// Serial constant-time comparator of an entered BCD PIN against the stored
// PIN. A start pulse arms it; it then compares exactly one digit per cycle
// for PIN_LEN cycles, OR-accumulating mismatches, so the time taken never
// depends on where (or whether) the first mismatch occurs.
// Ports:
//   CLK, RESET  clock and synchronous active-high reset
//   start       one-cycle pulse, begins a comparison on the next cycle
//   entry       entered PIN, packed BCD, most significant digit first
//   busy        comparison in progress
//   done        high in the last comparison cycle
//   mismatch    accumulated mismatch including the current digit
module pin_compare
    import pin_ctrl_pkg::*;
#(
    parameter int                    PIN_LEN   = 4,
    parameter logic [4*PIN_LEN-1:0]  PIN_VALUE = 16'h1234
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     start,
    input  logic [4*PIN_LEN-1:0]     entry,
    output logic                     busy,
    output logic                     done,
    output logic                     mismatch
);

    localparam int IDX_W = (PIN_LEN > 1) ? $clog2(PIN_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIN_LEN - 1);

    logic [IDX_W-1:0] idx_r;
    logic             busy_r;
    logic             mism_r;
    logic [3:0]       entry_digit_s;
    logic [3:0]       ref_digit_s;
    logic             digit_ne_s;

    // Select the digit pair addressed by the current index.
    always_comb begin
        entry_digit_s = 4'h0;
        ref_digit_s   = 4'h0;
        for (int i = 0; i < PIN_LEN; i++) begin
            if (idx_r == IDX_W'(i)) begin
                entry_digit_s = entry[4*(PIN_LEN-1-i) +: 4];
                ref_digit_s   = PIN_VALUE[4*(PIN_LEN-1-i) +: 4];
            end else begin
                entry_digit_s = entry_digit_s;
                ref_digit_s   = ref_digit_s;
            end
        end
        digit_ne_s = (entry_digit_s != ref_digit_s);
    end

    // Index walk and mismatch accumulation; never exits early.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy_r <= 1'b0;
            idx_r  <= {IDX_W{1'b0}};
            mism_r <= 1'b0;
        end else if (start) begin
            busy_r <= 1'b1;
            idx_r  <= {IDX_W{1'b0}};
            mism_r <= 1'b0;
        end else if (busy_r) begin
            mism_r <= mism_r | digit_ne_s;
            if (idx_r == LAST_IDX) begin
                busy_r <= 1'b0;
                idx_r  <= {IDX_W{1'b0}};
            end else begin
                idx_r  <= idx_r + IDX_W'(1);
            end
        end else begin
            busy_r <= busy_r;
            idx_r  <= idx_r;
            mism_r <= mism_r;
        end
    end

    assign busy     = busy_r;
    assign done     = busy_r && (idx_r == LAST_IDX);
    assign mismatch = mism_r | digit_ne_s;

endmodule

// File: rtl/pin_attempt_ctrl.sv
// pin_attempt_ctrl
// UART-driven PIN entry controller. Digits are collected until CR, checked in
// constant time against PIN_VALUE and answered with one byte:
// 'O' ok, 'F' fail, 'E' malformed/empty entry, 'L' locked out. MAX_TRIES
// consecutive failures lock the controller for LOCKOUT_CYCLES clocks.
// Ports:
//   CLK, RESET          clock and synchronous active-high reset
//   rx_valid, rx_data   received byte strobe and data
//   tx_ready            transmitter accepts tx_data when tx_valid is high
//   tx_valid, tx_data   response byte, held until accepted
//   unlocked            high after a correct PIN until the next entry starts
//   locked_out          high while in lockout
module pin_attempt_ctrl
    import pin_ctrl_pkg::*;
#(
    parameter int                    PIN_LEN        = 4,
    parameter logic [4*PIN_LEN-1:0]  PIN_VALUE      = 16'h1234,
    parameter int                    MAX_TRIES      = 3,
    parameter int                    LOCKOUT_CYCLES = 1000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        unlocked,
    output logic        locked_out
);

    localparam int CNT_W  = $clog2(PIN_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(PIN_LEN);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_TRIES);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

    pin_state_t state_r, state_nxt_s;

    logic [4*PIN_LEN-1:0] buf_r, buf_nxt_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
    logic                 ovf_r, ovf_nxt_s;
    logic                 err_r, err_nxt_s;
    logic [FAIL_W-1:0]    fail_r, fail_nxt_s;
    logic [LOCK_W-1:0]    lock_r, lock_nxt_s;
    logic                 lpend_r, lpend_nxt_s;

    logic                 tx_valid_r, tx_valid_nxt_s;
    logic [7:0]           tx_data_r, tx_data_nxt_s;
    logic                 unlocked_r, unlocked_nxt_s;
    logic                 locked_out_r, locked_out_nxt_s;

    logic rx_digit_s, rx_cr_s, rx_other_s, hs_s;
    logic cmp_start_s, cmp_busy_s, cmp_done_s, cmp_mismatch_s;
    logic pass_s;
    logic [7:0] check_resp_s;

    assign rx_digit_s  = rx_valid && is_digit(rx_data);
    assign rx_cr_s     = rx_valid && (rx_data == CHAR_CR);
    assign rx_other_s  = rx_valid && !is_digit(rx_data) && (rx_data != CHAR_CR);
    assign hs_s        = tx_valid_r && tx_ready;
    assign cmp_start_s = (state_r == ST_COLLECT) && rx_cr_s;

    // Buffer is frozen during CHECK because received bytes are dropped there.
    pin_compare #(
        .PIN_LEN   (PIN_LEN),
        .PIN_VALUE (PIN_VALUE)
    ) u_compare (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (cmp_start_s),
        .entry    (buf_r),
        .busy     (cmp_busy_s),
        .done     (cmp_done_s),
        .mismatch (cmp_mismatch_s)
    );

    assign pass_s       = !cmp_mismatch_s && (cnt_r == CNT_FULL) && !ovf_r && !err_r;
    assign check_resp_s = err_r ? RESP_ERR : (pass_s ? RESP_OK : RESP_FAIL);

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rx_cr_s)         state_nxt_s = ST_RESPOND;
                else if (rx_digit_s) state_nxt_s = ST_COLLECT;
                else                 state_nxt_s = ST_IDLE;
            end
            ST_COLLECT: begin
                if (rx_cr_s) state_nxt_s = ST_CHECK;
                else         state_nxt_s = ST_COLLECT;
            end
            ST_CHECK: begin
                if (cmp_done_s) state_nxt_s = ST_RESPOND;
                else            state_nxt_s = ST_CHECK;
            end
            ST_RESPOND: begin
                if (hs_s) state_nxt_s = (fail_r == FAIL_MAX) ? ST_LOCKOUT : ST_IDLE;
                else      state_nxt_s = ST_RESPOND;
            end
            ST_LOCKOUT: begin
                // A pending 'L' is drained before leaving lockout.
                if ((lock_r == {LOCK_W{1'b0}}) && (!lpend_r || hs_s)) state_nxt_s = ST_IDLE;
                else                                                   state_nxt_s = ST_LOCKOUT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs.
    always_comb begin
        tx_valid_nxt_s   = (state_nxt_s == ST_RESPOND) ||
                           ((state_nxt_s == ST_LOCKOUT) && lpend_nxt_s);
        locked_out_nxt_s = (state_nxt_s == ST_LOCKOUT);
        tx_data_nxt_s    = tx_data_r;
        unlocked_nxt_s   = unlocked_r;
        if ((state_r == ST_IDLE) && (state_nxt_s == ST_RESPOND)) begin
            tx_data_nxt_s = RESP_ERR;
        end else if ((state_r == ST_CHECK) && (state_nxt_s == ST_RESPOND)) begin
            tx_data_nxt_s = check_resp_s;
        end else if ((state_nxt_s == ST_LOCKOUT) && lpend_nxt_s) begin
            tx_data_nxt_s = RESP_LOCK;
        end else begin
            tx_data_nxt_s = tx_data_r;
        end
        if ((state_r == ST_IDLE) && rx_digit_s) begin
            unlocked_nxt_s = 1'b0;
        end else if ((state_r == ST_CHECK) && cmp_done_s && pass_s) begin
            unlocked_nxt_s = 1'b1;
        end else begin
            unlocked_nxt_s = unlocked_r;
        end
    end

    // Datapath next values: digit buffer, flags, fail and lockout counters.
    always_comb begin
        buf_nxt_s   = buf_r;
        cnt_nxt_s   = cnt_r;
        ovf_nxt_s   = ovf_r;
        err_nxt_s   = err_r;
        fail_nxt_s  = fail_r;
        lock_nxt_s  = lock_r;
        lpend_nxt_s = lpend_r;
        case (state_r)
            ST_IDLE, ST_COLLECT: begin
                if (rx_digit_s) begin
                    if (cnt_r < CNT_FULL) begin
                        for (int i = 0; i < PIN_LEN; i++) begin
                            if (cnt_r == CNT_W'(i)) buf_nxt_s[4*(PIN_LEN-1-i) +: 4] = ascii_to_bcd(rx_data);
                            else                    buf_nxt_s[4*(PIN_LEN-1-i) +: 4] = buf_r[4*(PIN_LEN-1-i) +: 4];
                        end
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end else begin
                        ovf_nxt_s = 1'b1;
                    end
                end else if (rx_other_s) begin
                    buf_nxt_s = {(4*PIN_LEN){1'b0}};
                    cnt_nxt_s = {CNT_W{1'b0}};
                    err_nxt_s = 1'b1;
                end else begin
                    buf_nxt_s = buf_r;
                end
            end
            ST_CHECK: begin
                // Error entries answer 'E' and leave the fail counter alone.
                if (cmp_done_s && !err_r) begin
                    if (pass_s)                fail_nxt_s = {FAIL_W{1'b0}};
                    else if (fail_r != FAIL_MAX) fail_nxt_s = fail_r + FAIL_W'(1);
                    else                       fail_nxt_s = fail_r;
                end else begin
                    fail_nxt_s = fail_r;
                end
            end
            ST_RESPOND: begin
                fail_nxt_s = fail_r;
            end
            ST_LOCKOUT: begin
                if (lock_r != {LOCK_W{1'b0}}) lock_nxt_s = lock_r - LOCK_W'(1);
                else                          lock_nxt_s = lock_r;
                lpend_nxt_s = (lpend_r && !hs_s) || rx_cr_s;
            end
            default: begin
                lpend_nxt_s = 1'b0;
            end
        endcase
        // Entry-into-state side effects override the per-state updates.
        if ((state_nxt_s == ST_IDLE) && (state_r != ST_IDLE)) begin
            buf_nxt_s   = {(4*PIN_LEN){1'b0}};
            cnt_nxt_s   = {CNT_W{1'b0}};
            ovf_nxt_s   = 1'b0;
            err_nxt_s   = 1'b0;
            lpend_nxt_s = 1'b0;
            if (state_r == ST_LOCKOUT) fail_nxt_s = {FAIL_W{1'b0}};
            else                       fail_nxt_s = fail_nxt_s;
        end else if ((state_nxt_s == ST_LOCKOUT) && (state_r != ST_LOCKOUT)) begin
            lock_nxt_s  = LOCK_LOAD;
            lpend_nxt_s = 1'b0;
        end else begin
            lock_nxt_s  = lock_nxt_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            buf_r        <= {(4*PIN_LEN){1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            ovf_r        <= 1'b0;
            err_r        <= 1'b0;
            fail_r       <= {FAIL_W{1'b0}};
            lock_r       <= {LOCK_W{1'b0}};
            lpend_r      <= 1'b0;
            tx_valid_r   <= 1'b0;
            tx_data_r    <= 8'h00;
            unlocked_r   <= 1'b0;
            locked_out_r <= 1'b0;
        end else begin
            buf_r        <= buf_nxt_s;
            cnt_r        <= cnt_nxt_s;
            ovf_r        <= ovf_nxt_s;
            err_r        <= err_nxt_s;
            fail_r       <= fail_nxt_s;
            lock_r       <= lock_nxt_s;
            lpend_r      <= lpend_nxt_s;
            tx_valid_r   <= tx_valid_nxt_s;
            tx_data_r    <= tx_data_nxt_s;
            unlocked_r   <= unlocked_nxt_s;
            locked_out_r <= locked_out_nxt_s;
        end
    end

    assign tx_valid   = tx_valid_r;
    assign tx_data    = tx_data_r;
    assign unlocked   = unlocked_r;
    assign locked_out = locked_out_r;

endmodule

// File: doc/pin_attempt_ctrl.md
PIN_ATTEMPT_CTRL -- requirements
Module: pin_attempt_ctrl

Interface
REQ-001 Parameter PIN_LEN, default 4, number of decimal digits in a PIN entry.
REQ-002 Parameter PIN_VALUE, default 16'h1234, stored PIN as packed BCD, 4*PIN_LEN bits, most significant digit first.
REQ-003 Parameter MAX_TRIES, default 3, consecutive failed checks that trigger lockout.
REQ-004 Parameter LOCKOUT_CYCLES, default 1000, lockout duration in CLK cycles.
REQ-005 CLK  input  1  sole clock, rising-edge.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 rx_valid  input  1  one-cycle strobe, rx_data holds a received UART byte.
REQ-008 rx_data  input  8  received byte.
REQ-009 tx_ready  input  1  UART transmitter can accept a byte.
REQ-010 tx_valid  output  1  response byte valid; held until tx_ready.
REQ-011 tx_data  output  8  response byte.
REQ-012 unlocked  output  1  high after a correct PIN until the next entry begins; drives LED1.
REQ-013 locked_out  output  1  high during lockout.

Function
REQ-014 States: IDLE, COLLECT, CHECK, RESPOND, LOCKOUT.
REQ-015 IDLE/COLLECT: ASCII '0'..'9' (0x30..0x39) stored as BCD into the next digit slot; first digit moves IDLE->COLLECT and clears unlocked.
REQ-016 Digits beyond PIN_LEN set a sticky overflow flag, not stored.
REQ-017 Byte 0x0D (CR) in COLLECT -> CHECK; CR in IDLE -> RESPOND with 'E' (0x45).
REQ-018 Any other byte in IDLE/COLLECT clears the buffer, sets error flag; the next CR responds 'E'.
REQ-019 CHECK lasts exactly PIN_LEN cycles regardless of mismatch position (constant-time, one digit compared per cycle, mismatches OR-accumulated).
REQ-020 Result: exact match, count==PIN_LEN, no overflow, no error -> 'O' (0x4F), unlocked=1, fail counter=0; otherwise 'F' (0x46), fail counter +1; short entries count as failures.
REQ-021 Error/empty entries ('E') do not change the fail counter.
REQ-022 RESPOND: tx_valid=1, tx_data stable until the cycle tx_valid&&tx_ready; then -> IDLE, or -> LOCKOUT if fail counter==MAX_TRIES.
REQ-023 LOCKOUT: locked_out=1, down-counter loaded with LOCKOUT_CYCLES-1; CR received -> response 'L' (0x4C), counter continues running; other bytes ignored.
REQ-024 Lockout expiry: counter==0 -> IDLE, fail counter=0, locked_out=0; if 'L' pending, it is sent first.
REQ-025 rx_valid in CHECK or RESPOND: byte dropped, no state effect.
REQ-026 Fail counter saturates at MAX_TRIES; width clog2(MAX_TRIES+1).
REQ-027 Buffer, count, overflow and error flags clear on entering IDLE.

Reset
REQ-028 RESET (sampled on CLK) -> IDLE, tx_valid=0, tx_data=0x00, unlocked=0, locked_out=0, fail counter=0, buffer/flags cleared.
REQ-029 RESET mid-CHECK, RESPOND or LOCKOUT aborts immediately; no response byte emitted afterwards.

Structure
REQ-030 Package pin_ctrl_pkg: state enum, response codes 'O','F','E','L', CR/digit constants.
REQ-031 Sub-module pin_compare: serial constant-time digit comparator (start, digit index, mismatch-accumulate, done after PIN_LEN cycles).

Verification
REQ-032 PIN 1234: send "1234\r", tx_ready=1 -> CHECK 4 cycles, tx_data 0x4F, unlocked=1.
REQ-033 Send "1299\r" and "9234\r" -> both 'F', identical CLK count from CR to tx_valid.
REQ-034 Three "0000\r" -> 'F','F','F', locked_out=1 for 1000 cycles; "1234\r" during lockout -> 'L', unlocked stays 0.
REQ-035 "12345\r" -> 'F'; "12a4\r" -> 'E', fail counter unchanged; bare "\r" -> 'E'.
REQ-036 tx_ready=0 for 20 cycles in RESPOND -> tx_valid/tx_data held; bytes sent then are dropped.
REQ-037 RESET asserted during CHECK -> next cycle IDLE, all outputs at reset values, no tx_valid.
